// File: rtl/div_iter32_pkg.sv
// Shared ALU definitions for the iterative RV32M divider: op encodings,
// controller states, width constants and sign-magnitude helpers.
package div_iter32_pkg;

  localparam int XLEN      = 32;
  localparam int CNT_W     = 6;
  localparam int DIV_ITERS = 32;

  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  // op[1] selects remainder, op[0] selects unsigned
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } div_state_e;

  // Two's complement negation modulo 2^32; INT_MIN maps onto itself, which
  // reads correctly as the unsigned magnitude 2^31.
  function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [XLEN-1:0] cond_neg32(input logic [XLEN-1:0] x,
                                                 input logic            en);
    logic [XLEN-1:0] r;
    if (en) begin
      r = neg32(x);
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_sub32.sv
// 32-bit subtractor a - b built on the carry-lookahead adder: b is inverted
// and carry-in is tied high. no_borrow_o is the adder carry-out (a >= b).
module div_sub32
  import div_iter32_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] diff_o,
  output logic            no_borrow_o
);

  logic [XLEN-1:0] bn_s;
  logic [XLEN-1:0] g_s;
  logic [XLEN-1:0] p_s;
  logic [XLEN:0]   c_s;

  assign bn_s = ~b_i;
  assign g_s  = a_i & bn_s;
  assign p_s  = a_i ^ bn_s;

  // Carry network: 4-bit groups with lookahead across group boundaries
  always_comb begin
    logic gg;
    logic pg;
    int   base;
    c_s    = '0;
    c_s[0] = 1'b1;
    gg     = 1'b0;
    pg     = 1'b0;
    base   = 0;
    for (int k = 0; k < XLEN / 4; k++) begin
      base = 4 * k;
      gg = g_s[base+3]
         | (p_s[base+3] & (g_s[base+2]
         | (p_s[base+2] & (g_s[base+1]
         | (p_s[base+1] & g_s[base])))));
      pg = &p_s[base +: 4];
      for (int j = 0; j < 3; j++) begin
        c_s[base+j+1] = g_s[base+j] | (p_s[base+j] & c_s[base+j]);
      end
      c_s[base+4] = gg | (pg & c_s[base]);
    end
  end

  assign diff_o      = p_s ^ c_s[XLEN-1:0];
  assign no_borrow_o = c_s[XLEN];

endmodule

// File: rtl/div_iter32.sv
// Iterative 32-bit restoring divider for DIV/DIVU/REM/REMU. One quotient bit
// per cycle through a single shared subtractor, then a sign-fix cycle.
module div_iter32
  import div_iter32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  div_state_e state_q, state_d;

  logic [1:0]       op_q, op_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]  divisor_q, divisor_d;
  // The partial remainder is architecturally 33 bits, but its top bit is
  // always zero after an update (a restored value has sh[32]=0), so only
  // the low 32 bits are stored.
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic [XLEN:0]    sh_s;
  logic [XLEN-1:0]  diff_s;
  logic             no_borrow_s;
  logic             ge_s;
  logic             accept_s;
  logic             in_signed_s;
  logic             div_zero_s;
  logic             overflow_s;
  logic             special_s;
  logic [XLEN-1:0]  special_res_s;
  logic             last_iter_s;

  assign sh_s        = {rem_q, quo_q[XLEN-1]};
  assign ge_s        = sh_s[XLEN] | no_borrow_s;
  assign accept_s    = (state_q == ST_IDLE) & start & ~kill;
  assign in_signed_s = ~op[0];
  assign div_zero_s  = (divisor == 32'h0000_0000);
  assign overflow_s  = in_signed_s & (dividend == INT_MIN) & (divisor == 32'hFFFF_FFFF);
  assign special_s   = div_zero_s | overflow_s;
  assign last_iter_s = (cnt_q == CNT_W'(DIV_ITERS - 1));

  // Result for the cases that bypass the iteration entirely
  always_comb begin
    special_res_s = 32'h0000_0000;
    if (div_zero_s) begin
      special_res_s = op[1] ? dividend : 32'hFFFF_FFFF;
    end else begin
      special_res_s = op[1] ? 32'h0000_0000 : INT_MIN;
    end
  end

  div_sub32 u_sub (
    .a_i         (sh_s[XLEN-1:0]),
    .b_i         (divisor_q),
    .diff_o      (diff_s),
    .no_borrow_o (no_borrow_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !special_s) begin
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (last_iter_s) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output and datapath next values
  always_comb begin
    op_d      = op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept_s && special_s) begin
          result_d = special_res_s;
          valid_d  = 1'b1;
        end else if (accept_s) begin
          op_d      = op;
          quo_neg_d = dividend[XLEN-1] ^ divisor[XLEN-1];
          rem_neg_d = dividend[XLEN-1];
          divisor_d = cond_neg32(divisor, in_signed_s & divisor[XLEN-1]);
          quo_d     = cond_neg32(dividend, in_signed_s & dividend[XLEN-1]);
          rem_d     = 32'h0000_0000;
          cnt_d     = '0;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_CALC: begin
        if (!kill) begin
          // When ge is clear sh[32] is zero, so sh fits the stored width
          rem_d = ge_s ? diff_s : sh_s[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], ge_s};
          cnt_d = cnt_q + 6'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_FIX: begin
        if (!kill) begin
          if (op_q[1]) begin
            result_d = cond_neg32(rem_q, ~op_q[0] & rem_neg_q);
          end else begin
            result_d = cond_neg32(quo_q, ~op_q[0] & quo_neg_q);
          end
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 2'b00;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      divisor_q <= 32'h0000_0000;
      rem_q     <= 32'h0000_0000;
      quo_q     <= 32'h0000_0000;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= 32'h0000_0000;
    end else begin
      op_q      <= op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_iter32.sv
// Directed bench for div_iter32: a vector table of single operations plus
// hand-written kill, reset and start-while-busy sequences.
module tb_div_iter32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        kill;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // edges: clock edges after the accepting edge until valid is seen
  // (0 = result produced on the accepting edge itself)
  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          edges;
  } vec_t;

  vec_t vq[$];

  div_iter32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .kill     (kill),
    .busy     (busy),
    .valid    (valid),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e, input int ed);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b; v.exp = e; v.edges = ed;
    vq.push_back(v);
  endtask

  // Issue one op, optionally pulse a stray start at edge 'inject' after
  // acceptance, then wait (bounded) for valid and check result/latency/busy.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_edges,
                        input int inject);
    int edges;
    int busy_drop;
    edges = 0;
    busy_drop = 0;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    while (!valid && edges < 60) begin
      if (!busy) busy_drop++;
      if (edges == inject) begin
        start = 1'b1; op = OP_REMU; dividend = 32'd9; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    check({name, " result"}, result, exp);
    check({name, " edges"}, 32'(edges), 32'(exp_edges));
    check({name, " busy_drop"}, 32'(busy_drop), 32'd0);
    check({name, " busy_at_valid"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int stray;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0; kill = 1'b0;

    add_vec("divu_100_7",      OP_DIVU, 32'd100,       32'd7,         32'd14,        33);
    add_vec("remu_100_7",      OP_REMU, 32'd100,       32'd7,         32'd2,         33);
    add_vec("div_m7_2",        OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    add_vec("rem_m7_2",        OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    add_vec("div_7_m2",        OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    add_vec("rem_m7_m2",       OP_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33);
    add_vec("divu_5_0",        OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    add_vec("remu_5_0",        OP_REMU, 32'd5,         32'd0,         32'd5,         0);
    add_vec("div_5_0",         OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    add_vec("rem_m7_0",        OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 0);
    add_vec("div_min_m1",      OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    add_vec("rem_min_m1",      OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
    add_vec("divu_min_ffff",   OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);
    add_vec("divu_ffff_1",     OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33);
    add_vec("remu_ffff_min",   OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33);
    add_vec("div_min_2",       OP_DIV,  32'h8000_0000, 32'd2,         32'hC000_0000, 33);
    add_vec("div_0_5",         OP_DIV,  32'd0,         32'd5,         32'd0,         33);
    add_vec("divu_1000_3",     OP_DIVU, 32'd1000,      32'd3,         32'd333,       33);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",   {31'd0, busy},  32'd0);
    check("reset valid",  {31'd0, valid}, 32'd0);
    check("reset result", result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table; consecutive entries are issued in the valid cycle (back-to-back)
    foreach (vq[i]) begin
      run_op(vq[i].name, vq[i].op, vq[i].a, vq[i].b, vq[i].exp, vq[i].edges, -1);
    end

    // start while busy is ignored; no second result appears afterwards
    run_op("ignore_start", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 5);
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) stray++;
    end
    check("ignore_start stray_valid", 32'(stray), 32'd0);

    // kill and start together in IDLE: start is dropped
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = OP_DIVU; dividend = 32'd5; divisor = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("idle_kill valid",  {31'd0, valid}, 32'd0);
    check("idle_kill busy",   {31'd0, busy},  32'd0);
    check("idle_kill result", result,         32'd14);

    // kill at edge 10 of DIVU 1000/3, with a stray start at edge 3
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_calc busy",   {31'd0, busy},  32'd0);
    check("kill_calc valid",  {31'd0, valid}, 32'd0);
    check("kill_calc result", result,         32'd14);
    run_op("after_kill divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, -1);

    // kill landing on the sign-fix edge suppresses the result
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_fix valid",  {31'd0, valid}, 32'd0);
    check("kill_fix busy",   {31'd0, busy},  32'd0);
    check("kill_fix result", result,         32'd3);

    // Asynchronous reset between edges in the middle of an operation
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst busy",   {31'd0, busy},  32'd0);
    check("async_rst valid",  {31'd0, valid}, 32'd0);
    check("async_rst result", result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst divu_8_2", OP_DIVU, 32'd8, 32'd2, 32'd4, 33, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
